rotor3_fwd_stage: RTL
=====================

Name: rotor3_fwd_stage

Overview:
- Forward (keyboard-to-reflector) path of rotor 3. It complements the existing combinational rotor-3 inverse path.
- It owns the rotor-3 position register, which the inverse path reads as its rotate input. It applies stepping and load commands and emits a turnover carry for the next rotor.
- It substitutes letters through the rotor-3 wiring offset by the current position, with one output register stage.
- Letter encoding is codebase-wide: 1 = A … 26 = Z, 0 = invalid. Position encoding: 0..25.

Parameters:
- NOTCH_POS, 21, position (0..25) from which a step generates carry_out (V→W turnover).
- RESET_POS, 0, position loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- step  input  1  advance position by one this cycle.
- load_en  input  1  load load_pos into position this cycle.
- load_pos  input  5  new position value.
- in_valid  input  1  in_letter is valid this cycle.
- in_letter  input  5  letter entering rotor (1..26).
- out_valid  output  1  out_letter is valid.
- out_letter  output  5  substituted letter (1..26).
- position  output  5  current rotor position (0..25); feeds the inverse path's rotate input.
- carry_out  output  1  one-cycle turnover pulse to the next rotor.

Behaviour:
- Reset (rst=1 at an edge): position=RESET_POS, out_valid=0, out_letter=0, carry_out=0. Reset overrides every other input in that cycle, including a transfer in flight.
- Position update priority per edge is rst > load_en > step.
  - load_en=1, load_pos 0..25: position ← load_pos; carry_out ← 0.
  - load_en=1, load_pos 26..31: position unchanged; carry_out ← 0.
  - step=1 without load: position ← position+1; 25 wraps to 0.
  - Neither: position holds.
- Carry:
  - carry_out ← 1 for exactly one cycle when a step is applied while position==NOTCH_POS.
  - carry_out is registered: it is high in the cycle after the step edge.
  - carry_out ← 0 in all other cases.
- Forward wiring W (in → W(in)): 1→14, 2→8, 3→24, 4→13, 5→16, 6→18, 7→20, 8→6, 9→19, 10→22, 11→25, 12→1, 13→10, 14→17, 15→2, 16→23, 17→5, 18→3, 19→4, 20→9, 21→26, 22→12, 23→11, 24→7, 25→21, 26→15.
- Substitution:
  - t = W(in_letter) + position, computed in 6 bits.
  - If t > 26 then t ← t − 26.
  - Result lies in 1..26.
  - Round-trip property: inverse(t, position) == in_letter.
- Latency:
  - in_valid=1 at edge N gives out_valid=1 and out_letter=result during cycle N+1.
  - in_valid=0 gives out_valid ← 0; out_letter holds its last value.
- Simultaneous events: substitution uses the position value before the same-edge step or load. The controller steps one cycle ahead of the keypress, as in a real machine.
- Invalid letter (in_letter 0 or 27..31) with in_valid=1: out_valid ← 1, out_letter ← 0.
- No backpressure: at most one letter per cycle, accepted unconditionally.

Optional Feature:
- Macro: ROTOR3_ERR_FLAG_EN.
- Defined:
  - Adds output err_sticky (1 bit, reset 0).
  - err_sticky sets on any in_valid=1 with an invalid letter, or any load_en=1 with load_pos > 25.
  - It holds until rst.
  - Invalid letters are dropped: out_valid ← 0 for that input.
- Undefined:
  - Port absent.
  - Invalid letters pass through as out_valid=1, out_letter=0, as described in Behaviour.

Test Plan:
- Reset, then in_valid=1, in_letter=1 at position 0 → next cycle out_valid=1, out_letter=14; position=0; carry_out=0.
- load_en=1, load_pos=5; then in_letter=21 → out_letter=5 (26+5−26); position=5.
- load_pos=21, pulse step once → position=22 and carry_out high for exactly one cycle. Stepping again from 22 gives no carry.
- load_pos=25, step → position=0, carry_out=0. Same edge with in_letter=26 → out_letter=14 (15+25−26), using pre-step position 25.
- load_en=1, step=1 same edge, load_pos=3 → position=3 (load wins). load_pos=30 → position unchanged.
- rst asserted while in_valid=1 → next cycle out_valid=0, out_letter=0, position=RESET_POS. With ROTOR3_ERR_FLAG_EN, in_letter=0 sets err_sticky=1 and out_valid stays 0.

Source files
------------

// File: rtl/rotor3_fwd_stage.sv
// Rotor-3 forward path: owns the position register, handles step/load/turnover,
// and substitutes one letter per cycle through a registered stage.
// Optional ROTOR3_ERR_FLAG_EN adds a sticky error flag and drops invalid letters.
module rotor3_fwd_stage #(
  parameter int unsigned NOTCH_POS = 21,
  parameter int unsigned RESET_POS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       load_en,
  input  logic [4:0] load_pos,
  input  logic       in_valid,
  input  logic [4:0] in_letter,
  output logic       out_valid,
  output logic [4:0] out_letter,
  output logic [4:0] position,
`ifdef ROTOR3_ERR_FLAG_EN
  output logic       err_sticky,
`endif
  output logic       carry_out
);

  localparam logic [4:0] NOTCH = 5'(NOTCH_POS);
  localparam logic [4:0] RPOS  = 5'(RESET_POS);

  function automatic logic [4:0] fwd_wire(input logic [4:0] l);
    logic [4:0] w;
    case (l)
      5'd1:  w = 5'd14;  5'd2:  w = 5'd8;   5'd3:  w = 5'd24;  5'd4:  w = 5'd13;
      5'd5:  w = 5'd16;  5'd6:  w = 5'd18;  5'd7:  w = 5'd20;  5'd8:  w = 5'd6;
      5'd9:  w = 5'd19;  5'd10: w = 5'd22;  5'd11: w = 5'd25;  5'd12: w = 5'd1;
      5'd13: w = 5'd10;  5'd14: w = 5'd17;  5'd15: w = 5'd2;   5'd16: w = 5'd23;
      5'd17: w = 5'd5;   5'd18: w = 5'd3;   5'd19: w = 5'd4;   5'd20: w = 5'd9;
      5'd21: w = 5'd26;  5'd22: w = 5'd12;  5'd23: w = 5'd11;  5'd24: w = 5'd7;
      5'd25: w = 5'd21;  5'd26: w = 5'd15;
      default: w = 5'd0;
    endcase
    return w;
  endfunction

  logic [4:0] pos_q, pos_d;
  logic       carry_q, carry_d;
  logic       vld_q, vld_d;
  logic [4:0] let_q, let_d;
  logic       letter_ok;
  logic [5:0] t_sum;
  logic [4:0] t_res;

  assign letter_ok = (in_letter >= 5'd1) && (in_letter <= 5'd26);

  always_comb begin
    pos_d   = pos_q;
    carry_d = 1'b0;
    if (load_en) begin
      if (load_pos <= 5'd25) pos_d = load_pos;
    end else if (step) begin
      pos_d   = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
      carry_d = (pos_q == NOTCH);
    end
  end

  // Substitution uses the pre-edge position, so the same-edge step affects the next letter only.
  always_comb begin
    t_sum = {1'b0, fwd_wire(in_letter)} + {1'b0, pos_q};
    t_res = (t_sum > 6'd26) ? 5'(t_sum - 6'd26) : t_sum[4:0];
  end

  always_comb begin
    vld_d = in_valid;
    let_d = let_q;
`ifdef ROTOR3_ERR_FLAG_EN
    vld_d = in_valid && letter_ok;
    if (in_valid && letter_ok) let_d = t_res;
`else
    if (in_valid) let_d = letter_ok ? t_res : 5'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= RPOS;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
      let_q   <= 5'd0;
    end else begin
      pos_q   <= pos_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
      let_q   <= let_d;
    end
  end

`ifdef ROTOR3_ERR_FLAG_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q | (in_valid && !letter_ok) | (load_en && (load_pos > 5'd25));
  end
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err_sticky = err_q;
`endif

  assign position   = pos_q;
  assign carry_out  = carry_q;
  assign out_valid  = vld_q;
  assign out_letter = let_q;

endmodule
